matrix_load_ctrl: RTL and testbench
===================================

// Module: matrix_load_ctrl
// PURPOSE
//  Sequences matrix ingest: consumes unpacked element words from the Ethernet
//  dibit aggregator, writes A/B elements into their BRAMs, detects complete load,
//  then hands memory ownership to the multiply engine and runs start/done handshake.
//  Sits between aggregator output and matrix BRAMs / compute core.
// PARAMETERS
//  ELEM_W  8  element value width
//  ROW_W   5  row index width (max 32 rows)
//  COL_W   5  col index width (max 32 cols)
//  WORD_W  1+ROW_W+COL_W+ELEM_W  (localparam) element word width
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous, active-low reset
//  cfg_valid  in   1        latch dimensions (accepted only in IDLE)
//  cfg_rows_a in   ROW_W+1  rows of A (1..2^ROW_W)
//  cfg_cols_a in   COL_W+1  cols of A = rows of B
//  cfg_cols_b in   COL_W+1  cols of B
//  elem_valid in   1        element word valid (1-cycle pulse per word)
//  elem_data  in   WORD_W   {type[0]=A/1=B, row, col, value}, MSB first
//  a_we/b_we  out  1        BRAM write enables
//  a_waddr/b_waddr out ROW_W+COL_W  write address = {row,col}
//  a_wdata/b_wdata out ELEM_W      write data
//  mem_owner  out  1        0 = loader owns BRAMs, 1 = compute owns
//  comp_start out  1        1-cycle start pulse to compute core
//  comp_done  in   1        compute-complete pulse
//  busy       out  1        high in any state except IDLE
//  load_err   out  1        1-cycle pulse on rejected input
//  done       out  1        1-cycle pulse when job completes
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, counters 0, latched dims 0.
//  FSM: IDLE -> LOAD -> START -> RUN -> DONE -> IDLE.
//  IDLE: cfg_valid with any dim==0 -> load_err, stay IDLE; else latch dims,
//   targets NA=rows_a*cols_a, NB=cols_a*cols_b, clear counts, -> LOAD.
//  LOAD: elem_valid decoded; bound check row<rows, col<cols of selected matrix
//   (B: rows=cols_a). In range -> registered write, 1-cycle latency (we/addr/data
//   valid the cycle after elem_valid); count_a/count_b +1. Out of range -> no
//   write, load_err pulse, count unchanged. Duplicate coordinates overwrite and
//   still count (no duplicate detection).
//  LOAD exit: cycle after count_a==NA && count_b==NB (last write already issued)
//   -> START; mem_owner goes 1 on entry to START. Counts saturate at target;
//   further elements of a full matrix -> load_err, no write.
//  START: comp_start=1 for exactly one cycle -> RUN.
//  RUN: wait comp_done; -> DONE. DONE: done=1 one cycle, mem_owner->0, -> IDLE.
//  elem_valid outside LOAD: dropped, load_err pulse. cfg_valid outside IDLE:
//   ignored silently. comp_done outside RUN: ignored.
//  elem_valid and completion same cycle: element processed first, then exit.
//  rst_n asserted mid-job: immediate return to reset state; partial BRAM
//   contents are don't-care, no write in flight completes.
//  Count width ROW_W+COL_W+1; products computed at cfg latch, unsigned.
// STRUCTURE
//  Shared package matrix_pkg: state enum, word field LSB/MSB localparams,
//   MAT_A/MAT_B type codes; reused by aggregator and compute core.
//  One sub-module: matrix_elem_unpack (combinational field split + bound check).
// TESTING
//  2x2*2x2 cfg, 8 in-range words -> 8 writes, addr {row,col}, comp_start 1 cycle
//   after 8th write; comp_done -> done pulse, mem_owner 1->0.
//  cfg rows_a=0 -> load_err pulse, busy stays 0, state IDLE.
//  A word row=3 with rows_a=2 -> no a_we, load_err, count_a unchanged.
//  5th A word on 2x2 A already full -> load_err, no write, no early START.
//  elem_valid in RUN and comp_done in LOAD -> load_err / ignored, no state change.
//  rst_n low during LOAD after 3 writes -> all outputs 0 next edge; new cfg reloads.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared matrix-ingest definitions: controller states, element word layout
// and matrix type codes, common to the aggregator, loader and compute core.
package matrix_pkg;

    localparam int DEF_ELEM_W = 8;
    localparam int DEF_ROW_W  = 5;
    localparam int DEF_COL_W  = 5;

    // Default word layout, MSB first: {type, row, col, value}
    localparam int VAL_LSB  = 0;
    localparam int VAL_MSB  = DEF_ELEM_W - 1;
    localparam int COL_LSB  = DEF_ELEM_W;
    localparam int COL_MSB  = COL_LSB + DEF_COL_W - 1;
    localparam int ROW_LSB  = COL_MSB + 1;
    localparam int ROW_MSB  = ROW_LSB + DEF_ROW_W - 1;
    localparam int TYPE_BIT = ROW_MSB + 1;

    localparam logic MAT_A = 1'b0;
    localparam logic MAT_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } ld_state_t;

endpackage

// File: rtl/matrix_elem_unpack.sv
// Splits an element word into its fields and checks the coordinates
// against the latched dimensions of the addressed matrix.
module matrix_elem_unpack
    import matrix_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int ROW_W  = DEF_ROW_W,
    parameter int COL_W  = DEF_COL_W
) (
    input  logic [ROW_W+COL_W+ELEM_W:0] i_word,
    input  logic [ROW_W:0]              i_rows_a,
    input  logic [COL_W:0]              i_cols_a,
    input  logic [COL_W:0]              i_cols_b,
    output logic                        o_is_b,
    output logic [ROW_W-1:0]            o_row,
    output logic [COL_W-1:0]            o_col,
    output logic [ELEM_W-1:0]           o_val,
    output logic                        o_in_range
);

    localparam int WORD_W = 1 + ROW_W + COL_W + ELEM_W;
    localparam int CW     = ROW_W + COL_W + 1;

    logic [CW-1:0] w_rows;
    logic [CW-1:0] w_cols;

    assign o_is_b = (i_word[WORD_W-1] == MAT_B);
    assign o_row  = i_word[ELEM_W+COL_W +: ROW_W];
    assign o_col  = i_word[ELEM_W +: COL_W];
    assign o_val  = i_word[ELEM_W-1:0];

    // B is indexed by cols_a rows and cols_b columns
    assign w_rows = o_is_b ? CW'(i_cols_a) : CW'(i_rows_a);
    assign w_cols = o_is_b ? CW'(i_cols_b) : CW'(i_cols_a);

    assign o_in_range = (CW'(o_row) < w_rows) && (CW'(o_col) < w_cols);

endmodule

// File: rtl/matrix_load_ctrl.sv
// Matrix ingest sequencer: writes A/B elements to BRAM, detects a full load,
// hands the memories to the compute core and runs the start/done handshake.
module matrix_load_ctrl
    import matrix_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int ROW_W  = DEF_ROW_W,
    parameter int COL_W  = DEF_COL_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    input  logic [ROW_W:0]              cfg_rows_a,
    input  logic [COL_W:0]              cfg_cols_a,
    input  logic [COL_W:0]              cfg_cols_b,
    input  logic                        elem_valid,
    input  logic [ROW_W+COL_W+ELEM_W:0] elem_data,
    output logic                        a_we,
    output logic [ROW_W+COL_W-1:0]      a_waddr,
    output logic [ELEM_W-1:0]           a_wdata,
    output logic                        b_we,
    output logic [ROW_W+COL_W-1:0]      b_waddr,
    output logic [ELEM_W-1:0]           b_wdata,
    output logic                        mem_owner,
    output logic                        comp_start,
    input  logic                        comp_done,
    output logic                        busy,
    output logic                        load_err,
    output logic                        done
);

    localparam int CNT_W = ROW_W + COL_W + 1;

    ld_state_t r_state;
    ld_state_t w_next;

    logic [ROW_W:0]       r_rows_a;
    logic [COL_W:0]       r_cols_a;
    logic [COL_W:0]       r_cols_b;
    logic [CNT_W-1:0]     r_na;
    logic [CNT_W-1:0]     r_nb;
    logic [CNT_W-1:0]     r_cnt_a;
    logic [CNT_W-1:0]     r_cnt_b;
    logic                 r_a_we;
    logic                 r_b_we;
    logic [CNT_W-2:0]     r_a_waddr;
    logic [CNT_W-2:0]     r_b_waddr;
    logic [ELEM_W-1:0]    r_a_wdata;
    logic [ELEM_W-1:0]    r_b_wdata;
    logic                 r_load_err;

    logic                 w_is_b;
    logic [ROW_W-1:0]     w_row;
    logic [COL_W-1:0]     w_col;
    logic [ELEM_W-1:0]    w_val;
    logic                 w_in_range;
    logic                 w_full_a;
    logic                 w_full_b;
    logic                 w_latch;
    logic                 w_wr_a;
    logic                 w_wr_b;
    logic                 w_err;
    logic [CNT_W-1:0]     w_prod_a;
    logic [CNT_W-1:0]     w_prod_b;

    matrix_elem_unpack #(
        .ELEM_W (ELEM_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_unpack (
        .i_word     (elem_data),
        .i_rows_a   (r_rows_a),
        .i_cols_a   (r_cols_a),
        .i_cols_b   (r_cols_b),
        .o_is_b     (w_is_b),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_val      (w_val),
        .o_in_range (w_in_range)
    );

    assign w_prod_a = {{COL_W{1'b0}}, cfg_rows_a} * {{ROW_W{1'b0}}, cfg_cols_a};
    assign w_prod_b = {{ROW_W{1'b0}}, cfg_cols_a} * {{ROW_W{1'b0}}, cfg_cols_b};
    assign w_full_a = (r_cnt_a == r_na);
    assign w_full_b = (r_cnt_b == r_nb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_wr_a  = 1'b0;
        w_wr_b  = 1'b0;
        w_err   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_err = elem_valid;
                if (cfg_valid) begin
                    if (cfg_rows_a == '0 || cfg_cols_a == '0 || cfg_cols_b == '0) begin
                        w_err = 1'b1;
                    end else begin
                        w_latch = 1'b1;
                        w_next  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (elem_valid) begin
                    if (w_in_range && !w_is_b && !w_full_a) begin
                        w_wr_a = 1'b1;
                    end else if (w_in_range && w_is_b && !w_full_b) begin
                        w_wr_b = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                // Counts are registered, so the last write is already out
                if (w_full_a && w_full_b) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                w_err  = elem_valid;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                w_err = elem_valid;
                if (comp_done) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_err  = elem_valid;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows_a   <= '0;
            r_cols_a   <= '0;
            r_cols_b   <= '0;
            r_na       <= '0;
            r_nb       <= '0;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_a_we     <= 1'b0;
            r_b_we     <= 1'b0;
            r_a_waddr  <= '0;
            r_b_waddr  <= '0;
            r_a_wdata  <= '0;
            r_b_wdata  <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_a_we     <= w_wr_a;
            r_b_we     <= w_wr_b;
            r_load_err <= w_err;
            if (w_latch) begin
                r_rows_a <= cfg_rows_a;
                r_cols_a <= cfg_cols_a;
                r_cols_b <= cfg_cols_b;
                r_na     <= w_prod_a;
                r_nb     <= w_prod_b;
                r_cnt_a  <= '0;
                r_cnt_b  <= '0;
            end
            if (w_wr_a) begin
                r_a_waddr <= {w_row, w_col};
                r_a_wdata <= w_val;
                r_cnt_a   <= r_cnt_a + CNT_W'(1);
            end
            if (w_wr_b) begin
                r_b_waddr <= {w_row, w_col};
                r_b_wdata <= w_val;
                r_cnt_b   <= r_cnt_b + CNT_W'(1);
            end
        end
    end

    assign a_we       = r_a_we;
    assign a_waddr    = r_a_waddr;
    assign a_wdata    = r_a_wdata;
    assign b_we       = r_b_we;
    assign b_waddr    = r_b_waddr;
    assign b_wdata    = r_b_wdata;
    assign load_err   = r_load_err;
    assign mem_owner  = (r_state == ST_START) || (r_state == ST_RUN);
    assign comp_start = (r_state == ST_START);
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Directed bench for matrix_load_ctrl: load/handshake sequence, rejected
// inputs, saturation and mid-job reset, with hand-computed expectations.
module tb_matrix_load_ctrl;

    localparam int ELEM_W = 8;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 5;
    localparam int WORD_W = 1 + ROW_W + COL_W + ELEM_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [ROW_W:0]    cfg_rows_a = '0;
    logic [COL_W:0]    cfg_cols_a = '0;
    logic [COL_W:0]    cfg_cols_b = '0;
    logic              elem_valid = 1'b0;
    logic [WORD_W-1:0] elem_data = '0;
    logic              a_we;
    logic [9:0]        a_waddr;
    logic [7:0]        a_wdata;
    logic              b_we;
    logic [9:0]        b_waddr;
    logic [7:0]        b_wdata;
    logic              mem_owner;
    logic              comp_start;
    logic              comp_done = 1'b0;
    logic              busy;
    logic              load_err;
    logic              done;

    int n_chk = 0;
    int n_err = 0;

    matrix_load_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_rows_a (cfg_rows_a),
        .cfg_cols_a (cfg_cols_a),
        .cfg_cols_b (cfg_cols_b),
        .elem_valid (elem_valid),
        .elem_data  (elem_data),
        .a_we       (a_we),
        .a_waddr    (a_waddr),
        .a_wdata    (a_wdata),
        .b_we       (b_we),
        .b_waddr    (b_waddr),
        .b_wdata    (b_wdata),
        .mem_owner  (mem_owner),
        .comp_start (comp_start),
        .comp_done  (comp_done),
        .busy       (busy),
        .load_err   (load_err),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk(input logic t, input logic [4:0] r,
                                             input logic [4:0] c, input logic [7:0] v);
        return {t, r, c, v};
    endfunction

    function automatic logic [63:0] all_out();
        return {21'd0, a_we, a_waddr, a_wdata, b_we, b_waddr, b_wdata,
                mem_owner, comp_start, busy, load_err, done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [5:0] ra, input logic [5:0] ca, input logic [5:0] cb);
        cfg_valid  = 1'b1;
        cfg_rows_a = ra;
        cfg_cols_a = ca;
        cfg_cols_b = cb;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic elem(input logic [WORD_W-1:0] w);
        elem_valid = 1'b1;
        elem_data  = w;
        step();
        elem_valid = 1'b0;
    endtask

    task automatic pulse_done();
        comp_done = 1'b1;
        step();
        comp_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       t;
        logic [4:0] r;
        logic [4:0] c;
        logic [7:0] v;

        #1;
        chk("reset_outs", all_out(), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // 2x2 * 2x2 full job
        cfg(6'd2, 6'd2, 6'd2);
        chk("cfg_busy", {busy, load_err}, 2'b10);
        for (int i = 0; i < 8; i++) begin
            t = (i >= 4);
            r = 5'((i >> 1) & 1);
            c = 5'(i & 1);
            v = 8'(8'h10 + i);
            elem(mk(t, r, c, v));
            if (!t)
                chk($sformatf("wr_a%0d", i), {a_we, a_waddr, a_wdata, b_we},
                    {1'b1, r, c, v, 1'b0});
            else
                chk($sformatf("wr_b%0d", i), {b_we, b_waddr, b_wdata, a_we},
                    {1'b1, r, c, v, 1'b0});
        end
        chk("no_early_start", {comp_start, mem_owner, busy}, 3'b001);
        step();
        chk("start", {comp_start, mem_owner, busy, b_we}, 4'b1110);
        step();
        chk("run", {comp_start, mem_owner, busy, done}, 4'b0110);
        pulse_done();
        chk("done", {done, mem_owner, busy}, 3'b101);
        step();
        chk("idle", {done, mem_owner, busy}, 3'b000);

        // zero dimension rejected
        cfg(6'd0, 6'd2, 6'd2);
        chk("cfg_zero", {load_err, busy}, 2'b10);
        step();
        chk("cfg_zero_end", {load_err, busy}, 2'b00);

        // element while idle
        elem(mk(1'b0, 5'd0, 5'd0, 8'h01));
        chk("idle_elem", {load_err, a_we, busy}, 3'b100);

        // bad coordinates, saturation, comp_done in LOAD
        cfg(6'd2, 6'd2, 6'd2);
        elem(mk(1'b0, 5'd3, 5'd0, 8'h55));
        chk("row_oob", {a_we, load_err}, 2'b01);
        elem(mk(1'b1, 5'd0, 5'd2, 8'h56));
        chk("col_oob_b", {b_we, load_err}, 2'b01);
        elem(mk(1'b0, 5'd0, 5'd0, 8'h60));
        elem(mk(1'b0, 5'd0, 5'd1, 8'h61));
        elem(mk(1'b0, 5'd1, 5'd0, 8'h62));
        pulse_done();
        chk("done_in_load", {busy, comp_start, done, mem_owner}, 4'b1000);
        elem(mk(1'b0, 5'd1, 5'd1, 8'h63));
        chk("a4_written", {a_we, a_waddr, a_wdata, load_err}, {1'b1, 5'd1, 5'd1, 8'h63, 1'b0});
        elem(mk(1'b0, 5'd0, 5'd0, 8'h64));
        chk("a5_sat", {a_we, load_err, comp_start}, 3'b010);
        elem(mk(1'b1, 5'd0, 5'd0, 8'h70));
        elem(mk(1'b1, 5'd0, 5'd1, 8'h71));
        elem(mk(1'b1, 5'd1, 5'd0, 8'h72));
        chk("b3_no_start", {b_we, comp_start}, 2'b10);
        elem(mk(1'b1, 5'd1, 5'd1, 8'h73));
        chk("b4_written", {b_we, b_waddr, b_wdata}, {1'b1, 5'd1, 5'd1, 8'h73});
        step();
        chk("start2", {comp_start, mem_owner}, 2'b11);
        step();
        elem(mk(1'b0, 5'd0, 5'd0, 8'h99));
        chk("elem_in_run", {load_err, a_we, busy, comp_start, done}, 5'b10100);
        pulse_done();
        chk("done2", {done, mem_owner, load_err}, 3'b100);
        step();
        chk("idle2", busy, 1'b0);

        // reset mid-load after three writes
        cfg(6'd2, 6'd2, 6'd2);
        elem(mk(1'b0, 5'd0, 5'd0, 8'h01));
        elem(mk(1'b0, 5'd0, 5'd1, 8'h02));
        elem(mk(1'b0, 5'd1, 5'd0, 8'h03));
        elem_valid = 1'b1;
        elem_data  = mk(1'b0, 5'd1, 5'd1, 8'h04);
        rst_n      = 1'b0;
        #1;
        chk("midrst_outs", all_out(), 64'd0);
        step();
        chk("midrst_hold", all_out(), 64'd0);
        elem_valid = 1'b0;
        rst_n      = 1'b1;
        step();
        chk("post_rst_idle", {busy, load_err}, 2'b00);

        // fresh 1x1 job after reset
        cfg(6'd1, 6'd1, 6'd1);
        elem(mk(1'b0, 5'd0, 5'd0, 8'hAA));
        chk("r_wr_a", {a_we, a_waddr, a_wdata}, {1'b1, 10'd0, 8'hAA});
        elem(mk(1'b1, 5'd0, 5'd0, 8'hBB));
        chk("r_wr_b", {b_we, b_waddr, b_wdata, comp_start}, {1'b1, 10'd0, 8'hBB, 1'b0});
        step();
        chk("r_start", {comp_start, mem_owner}, 2'b11);
        step();
        pulse_done();
        chk("r_done", {done, mem_owner}, 2'b10);
        step();
        chk("r_idle", {busy, done}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
